// File: rtl/reg_bank_writer.sv
// reg_bank_writer: write side of an 8-entry register bank.
// A start command loads a target pointer and a burst count. Data beats then
// arrive over valid/ready and land in consecutive registers, wrapping 7 -> 0.
// All eight registers are driven out in parallel.
module reg_bank_writer #(
  parameter int unsigned           WIDTH     = 16,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       wr_sel,
  input  logic [2:0]       wr_len,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] reg0,
  output logic [WIDTH-1:0] reg1,
  output logic [WIDTH-1:0] reg2,
  output logic [WIDTH-1:0] reg3,
  output logic [WIDTH-1:0] reg4,
  output logic [WIDTH-1:0] reg5,
  output logic [WIDTH-1:0] reg6,
  output logic [WIDTH-1:0] reg7
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             wr_en;
  logic [WIDTH-1:0] bank_q [8];

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: accept start in IDLE, count beats in ACTIVE
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACTIVE;
          ptr_d   = wr_sel;
          cnt_d   = wr_len;
        end
      end
      ACTIVE: begin
        if (in_valid) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + 3'd1;  // natural 3-bit wrap 7 -> 0
          if (cnt_q == 3'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register bank: one entry written per accepted beat
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) bank_q[i] <= RESET_VAL;
    end else if (wr_en) begin
      bank_q[ptr_q] <= in_data;
    end
  end

  // Handshake/status come straight from registered state
  assign in_ready = (state_q == ACTIVE);
  assign busy     = (state_q == ACTIVE);
  assign done     = done_q;

  assign reg0 = bank_q[0];
  assign reg1 = bank_q[1];
  assign reg2 = bank_q[2];
  assign reg3 = bank_q[3];
  assign reg4 = bank_q[4];
  assign reg5 = bank_q[5];
  assign reg6 = bank_q[6];
  assign reg7 = bank_q[7];

endmodule

// File: tb/tb_reg_bank_writer.sv
// Self-checking bench for reg_bank_writer: directed scenarios plus random
// traffic, all compared against a transaction-level reference model.
module tb_reg_bank_writer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset, start, in_valid;
  logic [2:0]   wr_sel, wr_len;
  logic [W-1:0] in_data;
  logic         in_ready, busy, done;
  logic [W-1:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
  logic [W-1:0] r [8];

  reg_bank_writer #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk(clk), .reset(reset), .start(start), .wr_sel(wr_sel), .wr_len(wr_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .busy(busy),
    .done(done), .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
    .reg4(reg4), .reg5(reg5), .reg6(reg6), .reg7(reg7)
  );

  assign r[0] = reg0; assign r[1] = reg1; assign r[2] = reg2; assign r[3] = reg3;
  assign r[4] = reg4; assign r[5] = reg5; assign r[6] = reg6; assign r[7] = reg7;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a transaction is "beats remaining" to an address
  logic [W-1:0] m_reg [8];
  bit           m_act, m_done;
  int           m_addr, m_left;

  // Advance one clock, updating the model from the inputs seen at the edge
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      m_act = 0; m_done = 0; m_addr = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (!m_act) begin
        if (start) begin
          m_act  = 1;
          m_addr = wr_sel;
          m_left = int'(wr_len) + 1;
        end
      end else if (in_valid) begin
        m_reg[m_addr] = in_data;
        m_addr = (m_addr + 1) % 8;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_act  = 0;
          m_done = 1;
        end
      end
    end
    #1;
  endtask

  task automatic quiet();
    start = 0; in_valid = 0; wr_sel = 0; wr_len = 0; in_data = '0;
  endtask

  task automatic test_reset();
    quiet();
    reset = 1;
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r[i] !== 16'h0000) begin errors++; $display("FAIL reset reg%0d got %h exp 0000", i, r[i]); end
    end
    checks++;
    if ({in_ready, busy, done} !== 3'b000) begin
      errors++; $display("FAIL reset flags got %b exp 000", {in_ready, busy, done});
    end
    reset = 0;
    tick();
  endtask

  task automatic test_single();
    start = 1; wr_sel = 5; wr_len = 0;
    tick();
    start = 0; wr_sel = $urandom; wr_len = $urandom;
    checks++;
    if ({in_ready, busy, done} !== 3'b110) begin
      errors++; $display("FAIL single accept flags got %b exp 110", {in_ready, busy, done});
    end
    in_valid = 1; in_data = 16'hBEEF;
    tick();
    quiet();
    checks++;
    if (reg5 !== 16'hBEEF) begin errors++; $display("FAIL single reg5 got %h exp BEEF", reg5); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r[i] !== m_reg[i]) begin errors++; $display("FAIL single reg%0d got %h exp %h", i, r[i], m_reg[i]); end
    end
    checks++;
    if ({busy, done} !== 2'b01) begin errors++; $display("FAIL single done-cycle got %b exp 01", {busy, done}); end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL single done-width got %b exp 0", done); end
  endtask

  task automatic test_wrap();
    start = 1; wr_sel = 6; wr_len = 3;
    tick();
    start = 0;
    for (int b = 1; b <= 4; b++) begin
      in_valid = 1; in_data = W'(b);
      tick();
      checks++;
      if ({busy, done} !== {m_act, m_done}) begin
        errors++; $display("FAIL wrap beat%0d busy/done got %b exp %b", b, {busy, done}, {m_act, m_done});
      end
    end
    quiet();
    checks++;
    if ({reg6, reg7, reg0, reg1} !== {16'd1, 16'd2, 16'd3, 16'd4}) begin
      errors++; $display("FAIL wrap regs got %h %h %h %h exp 1 2 3 4", reg6, reg7, reg0, reg1);
    end
    tick();
  endtask

  task automatic test_gaps();
    logic [5:0]   vpat;
    logic [W-1:0] dat [6];
    vpat = 6'b101001;  // bit k = in_valid on beat slot k
    for (int k = 0; k < 6; k++) dat[k] = W'($urandom);
    start = 1; wr_sel = 0; wr_len = 2;
    tick();
    start = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = vpat[k]; in_data = dat[k];
      tick();
      checks++;
      if ({in_ready, busy, done} !== {m_act, m_act, m_done}) begin
        errors++; $display("FAIL gaps slot%0d flags got %b exp %b", k, {in_ready, busy, done}, {m_act, m_act, m_done});
      end
    end
    quiet();
    checks++;
    if ({reg0, reg1, reg2} !== {dat[0], dat[3], dat[5]}) begin
      errors++; $display("FAIL gaps regs got %h %h %h exp %h %h %h", reg0, reg1, reg2, dat[0], dat[3], dat[5]);
    end
    tick();
  endtask

  task automatic test_abort_and_ignore();
    start = 1; wr_sel = 2; wr_len = 7;
    tick();
    start = 0;
    for (int b = 0; b < 2; b++) begin in_valid = 1; in_data = W'($urandom) | 16'h1; tick(); end
    quiet();
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r[i] !== '0) begin errors++; $display("FAIL abort reg%0d got %h exp 0000", i, r[i]); end
    end
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort flags got %b exp 00", {busy, done}); end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL abort late-done got %b exp 0", done); end
    // start during ACTIVE, including the last-beat edge, must be ignored
    start = 1; wr_sel = 4; wr_len = 1;
    tick();
    wr_sel = 1; wr_len = 5;           // start still high, in ACTIVE
    tick();
    in_valid = 1; in_data = 16'hAAAA; tick();
    in_data = 16'h5555;               // last beat with start high
    tick();
    start = 0; in_valid = 0;
    checks++;
    if ({reg4, reg5, reg1} !== {16'hAAAA, 16'h5555, 16'h0000} || {busy, done} !== 2'b01) begin
      errors++; $display("FAIL ignore got %h %h %h %b exp AAAA 5555 0000 01", reg4, reg5, reg1, {busy, done});
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore post busy got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    start = 1; wr_sel = 0; wr_len = 7;
    tick();
    start = 0;
    for (int i = 0; i < 8; i++) begin in_valid = 1; in_data = 16'h1000 + W'(i); tick(); end
    in_valid = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r[i] !== 16'h1000 + W'(i)) begin errors++; $display("FAIL full reg%0d got %h exp %h", i, r[i], 16'h1000 + W'(i)); end
    end
    // done cycle: a new start must be accepted
    start = 1; wr_sel = 3; wr_len = 0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b done got %b exp 1", done); end
    tick();
    start = 0;
    checks++;
    if ({busy, in_ready} !== 2'b11) begin errors++; $display("FAIL b2b accept got %b exp 11", {busy, in_ready}); end
    in_valid = 1; in_data = 16'hCAFE;
    tick();
    quiet();
    checks++;
    if (reg3 !== 16'hCAFE || done !== 1'b1) begin
      errors++; $display("FAIL b2b write got %h %b exp CAFE 1", reg3, done);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset    = ($urandom_range(0, 59) == 0);
      start    = ($urandom_range(0, 2) == 0);
      wr_sel   = 3'($urandom);
      wr_len   = 3'($urandom);
      in_valid = $urandom_range(0, 1) == 1;
      in_data  = W'($urandom);
      tick();
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (r[i] !== m_reg[i]) begin errors++; $display("FAIL random c%0d reg%0d got %h exp %h", c, i, r[i], m_reg[i]); end
      end
      checks++;
      if ({in_ready, busy, done} !== {m_act, m_act, m_done}) begin
        errors++; $display("FAIL random c%0d flags got %b exp %b", c, {in_ready, busy, done}, {m_act, m_act, m_done});
      end
    end
    reset = 0;
    quiet();
  endtask

  initial begin
    reset = 1;
    quiet();
    test_reset();
    test_single();
    test_wrap();
    test_gaps();
    test_abort_and_ignore();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
